// File: rtl/ascii_token_parser.sv
// ascii_token_parser
//   Turns a stream of ASCII characters into calculator tokens. Decimal digits
//   are accumulated into an operand. Operator, '=' and 'c' characters each
//   emit one registered token. Backspace removes the last digit. Overflow
//   leaves the parser in a sticky error state, and only 'c' clears it.
//
// Ports
//   clk        : rising-edge clock
//   rst        : synchronous active-high reset
//   in_valid   : in_char is valid this cycle (one character per cycle)
//   in_char    : ASCII code
//   out_valid  : one-cycle token pulse
//   out_num    : operand value (0 for pure commands), held until next token
//   out_mode   : 0 none, 1 '+', 2 '-', 3 '*', 4 '/', 5 's', 6 '=', 7 'c'
//   out_status : 00 ok, 01 overflow, 10 invalid char, 11 operator without operand
//   print_en   : one-cycle pulse together with an '=' token
module ascii_token_parser #(
    parameter int NUM_W      = 10,
    parameter int MAX_DIGITS = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [7:0]       in_char,
    output logic             out_valid,
    output logic [NUM_W-1:0] out_num,
    output logic [2:0]       out_mode,
    output logic [1:0]       out_status,
    output logic             print_en
);

    localparam int CNT_W  = $clog2(MAX_DIGITS + 1);
    // acc*10+9 always fits in four extra bits, so the candidate never wraps.
    localparam int CAND_W = NUM_W + 4;

    localparam logic [7:0] CH_PLUS  = 8'h2B;
    localparam logic [7:0] CH_MINUS = 8'h2D;
    localparam logic [7:0] CH_MUL   = 8'h2A;
    localparam logic [7:0] CH_DIV   = 8'h2F;
    localparam logic [7:0] CH_S     = 8'h73;
    localparam logic [7:0] CH_EQ    = 8'h3D;
    localparam logic [7:0] CH_C     = 8'h63;
    localparam logic [7:0] CH_BS    = 8'h08;
    localparam logic [7:0] CH_0     = 8'h30;
    localparam logic [7:0] CH_9     = 8'h39;

    localparam logic [1:0] ST_OK    = 2'b00;
    localparam logic [1:0] ST_OVF   = 2'b01;
    localparam logic [1:0] ST_INV   = 2'b10;
    localparam logic [1:0] ST_SYN   = 2'b11;

    typedef enum logic [1:0] {IDLE, NUM, ERR} state_t;

    state_t            state, state_nxt;
    logic [NUM_W-1:0]  acc, acc_nxt;
    logic [CNT_W-1:0]  cnt, cnt_nxt;

    logic              tok_vld;
    logic              tok_print;
    logic [NUM_W-1:0]  tok_num;
    logic [2:0]        tok_mode;
    logic [1:0]        tok_status;

    logic              is_digit;
    logic              is_op;
    logic [2:0]        op_mode;
    logic [CAND_W-1:0] cand;
    logic              overflow;

    // Character decode and overflow candidate
    always_comb begin
        is_digit = (in_char >= CH_0) && (in_char <= CH_9);
        is_op    = 1'b1;
        op_mode  = 3'd0;
        case (in_char)
            CH_PLUS:  op_mode = 3'd1;
            CH_MINUS: op_mode = 3'd2;
            CH_MUL:   op_mode = 3'd3;
            CH_DIV:   op_mode = 3'd4;
            CH_S:     op_mode = 3'd5;
            default:  is_op   = 1'b0;
        endcase
        // The low nibble of an ASCII digit is its value.
        cand     = {4'd0, acc} * CAND_W'(10) + {{NUM_W{1'b0}}, in_char[3:0]};
        overflow = (cnt == CNT_W'(MAX_DIGITS)) || (cand[CAND_W-1:NUM_W] != '0);
    end

    // Next-state and token generation
    always_comb begin
        state_nxt  = state;
        acc_nxt    = acc;
        cnt_nxt    = cnt;
        tok_vld    = 1'b0;
        tok_print  = 1'b0;
        tok_num    = '0;
        tok_mode   = 3'd0;
        tok_status = ST_OK;

        if (in_valid) begin
            if (in_char == CH_C) begin
                tok_vld   = 1'b1;
                tok_mode  = 3'd7;
                acc_nxt   = '0;
                cnt_nxt   = '0;
                state_nxt = IDLE;
            end else if (state != ERR) begin
                if (is_digit) begin
                    if (overflow) begin
                        // acc is left untouched; ERR holds until 'c'.
                        tok_vld    = 1'b1;
                        tok_status = ST_OVF;
                        state_nxt  = ERR;
                    end else begin
                        acc_nxt   = cand[NUM_W-1:0];
                        cnt_nxt   = cnt + 1'b1;
                        state_nxt = NUM;
                    end
                end else if (is_op) begin
                    tok_vld  = 1'b1;
                    tok_mode = op_mode;
                    if (state == NUM) begin
                        tok_num   = acc;
                        acc_nxt   = '0;
                        cnt_nxt   = '0;
                        state_nxt = IDLE;
                    end else begin
                        tok_status = ST_SYN;
                    end
                end else if (in_char == CH_EQ) begin
                    tok_vld   = 1'b1;
                    tok_mode  = 3'd6;
                    tok_print = 1'b1;
                    if (state == NUM) begin
                        tok_num   = acc;
                        acc_nxt   = '0;
                        cnt_nxt   = '0;
                        state_nxt = IDLE;
                    end
                end else if (in_char == CH_BS) begin
                    if (state == NUM) begin
                        acc_nxt = acc / NUM_W'(10);
                        cnt_nxt = cnt - 1'b1;
                        if (cnt == CNT_W'(1)) begin
                            state_nxt = IDLE;
                        end
                    end
                end else begin
                    tok_vld    = 1'b1;
                    tok_status = ST_INV;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            acc        <= '0;
            cnt        <= '0;
            out_valid  <= 1'b0;
            print_en   <= 1'b0;
            out_num    <= '0;
            out_mode   <= 3'd0;
            out_status <= ST_OK;
        end else begin
            state     <= state_nxt;
            acc       <= acc_nxt;
            cnt       <= cnt_nxt;
            out_valid <= tok_vld;
            print_en  <= tok_print;
            // Token fields hold their value between tokens.
            if (tok_vld) begin
                out_num    <= tok_num;
                out_mode   <= tok_mode;
                out_status <= tok_status;
            end
        end
    end

endmodule

// File: tb/tb_ascii_token_parser.sv
// Testbench for ascii_token_parser: two instances (NUM_W=10/MAX_DIGITS=4 and
// NUM_W=16/MAX_DIGITS=5) driven by directed character sequences; expected
// tokens are queued on drive and popped when the DUT is sampled.
module tb_ascii_token_parser;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        in_valid_a, in_valid_b;
    logic [7:0]  in_char_a, in_char_b;

    logic        out_valid_a, print_en_a;
    logic [9:0]  out_num_a;
    logic [2:0]  out_mode_a;
    logic [1:0]  out_status_a;

    logic        out_valid_b, print_en_b;
    logic [15:0] out_num_b;
    logic [2:0]  out_mode_b;
    logic [1:0]  out_status_b;

    ascii_token_parser #(.NUM_W(10), .MAX_DIGITS(4)) dut_a (
        .clk(clk), .rst(rst), .in_valid(in_valid_a), .in_char(in_char_a),
        .out_valid(out_valid_a), .out_num(out_num_a), .out_mode(out_mode_a),
        .out_status(out_status_a), .print_en(print_en_a)
    );

    ascii_token_parser #(.NUM_W(16), .MAX_DIGITS(5)) dut_b (
        .clk(clk), .rst(rst), .in_valid(in_valid_b), .in_char(in_char_b),
        .out_valid(out_valid_b), .out_num(out_num_b), .out_mode(out_mode_b),
        .out_status(out_status_b), .print_en(print_en_b)
    );

    typedef struct {
        logic [15:0] num;
        logic [2:0]  mode;
        logic [1:0]  status;
        logic        print;
    } tok_t;

    tok_t sb_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Compare DUT outputs against the scoreboard after an edge.
    task automatic sample(input bit sel_b, input string tag);
        logic        v, p;
        logic [15:0] n;
        logic [2:0]  m;
        logic [1:0]  s;
        tok_t        t;
        v = sel_b ? out_valid_b  : out_valid_a;
        p = sel_b ? print_en_b   : print_en_a;
        n = sel_b ? out_num_b    : {6'd0, out_num_a};
        m = sel_b ? out_mode_b   : out_mode_a;
        s = sel_b ? out_status_b : out_status_a;
        if (sb_q.size() > 0) begin
            t = sb_q.pop_front();
            chk({tag, "_valid"},  32'(v), 32'd1);
            chk({tag, "_num"},    32'(n), 32'(t.num));
            chk({tag, "_mode"},   32'(m), 32'(t.mode));
            chk({tag, "_status"}, 32'(s), 32'(t.status));
            chk({tag, "_print"},  32'(p), 32'(t.print));
        end else begin
            chk({tag, "_novalid"}, 32'(v), 32'd0);
            chk({tag, "_noprint"}, 32'(p), 32'd0);
        end
    endtask

    task automatic drive(input bit sel_b, input logic [7:0] c);
        if (sel_b) begin
            in_valid_b = 1'b1;
            in_char_b  = c;
        end else begin
            in_valid_a = 1'b1;
            in_char_a  = c;
        end
        @(posedge clk);
        #1;
        in_valid_a = 1'b0;
        in_valid_b = 1'b0;
        sample(sel_b, $sformatf("%s_ch%02h", sel_b ? "b" : "a", c));
    endtask

    // Character that must not produce a token.
    task automatic quiet(input bit sel_b, input logic [7:0] c);
        drive(sel_b, c);
    endtask

    // Character that must produce exactly this token.
    task automatic tok(input bit sel_b, input logic [7:0] c, input logic [15:0] n,
                       input logic [2:0] m, input logic [1:0] s, input logic p);
        tok_t t;
        t.num = n; t.mode = m; t.status = s; t.print = p;
        sb_q.push_back(t);
        drive(sel_b, c);
    endtask

    task automatic quiet_str(input bit sel_b, input string str);
        for (int i = 0; i < str.len(); i++) begin
            quiet(sel_b, str[i]);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst        = 1'b1;
        in_valid_a = 1'b0;
        in_valid_b = 1'b0;
        in_char_a  = 8'h00;
        in_char_b  = 8'h00;
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("rst_valid",  32'(out_valid_a),  32'd0);
        chk("rst_num",    32'(out_num_a),    32'd0);
        chk("rst_mode",   32'(out_mode_a),   32'd0);
        chk("rst_status", 32'(out_status_a), 32'd0);
        chk("rst_print",  32'(print_en_a),   32'd0);
        rst = 1'b0;

        // "36s"
        quiet_str(0, "36");
        tok(0, "s", 16'd36, 3'd5, 2'b00, 1'b0);

        // "1023+" then idle cycle holds fields, then '=' from IDLE
        quiet_str(0, "1023");
        tok(0, "+", 16'd1023, 3'd1, 2'b00, 1'b0);
        @(posedge clk);
        #1;
        sample(0, "idle");
        chk("hold_num",  32'(out_num_a),  32'd1023);
        chk("hold_mode", 32'(out_mode_a), 32'd1);
        tok(0, "=", 16'd0, 3'd6, 2'b00, 1'b1);

        // Overflow by value, sticky error, clear, recover
        quiet_str(0, "102");
        tok(0, "4", 16'd0, 3'd0, 2'b01, 1'b0);
        quiet_str(0, "5+");
        tok(0, "c", 16'd0, 3'd7, 2'b00, 1'b0);
        quiet(0, "7");
        tok(0, "=", 16'd7, 3'd6, 2'b00, 1'b1);

        // 9999 exceeds 1023 on the fourth digit
        quiet_str(0, "999");
        tok(0, "9", 16'd0, 3'd0, 2'b01, 1'b0);
        quiet(0, "9");
        tok(0, "c", 16'd0, 3'd7, 2'b00, 1'b0);

        // Digit-count limit: fifth digit with small value
        quiet_str(0, "0001");
        tok(0, "2", 16'd0, 3'd0, 2'b01, 1'b0);
        tok(0, "c", 16'd0, 3'd7, 2'b00, 1'b0);

        // Backspace, invalid char, syntax error
        quiet_str(0, "42");
        quiet(0, 8'h08);
        quiet(0, "7");
        tok(0, "-", 16'd47, 3'd2, 2'b00, 1'b0);
        quiet(0, 8'h08);
        tok(0, "#", 16'd0, 3'd0, 2'b10, 1'b0);
        quiet_str(0, "12");
        tok(0, "#", 16'd0, 3'd0, 2'b10, 1'b0);
        tok(0, "+", 16'd12, 3'd1, 2'b00, 1'b0);
        tok(0, "*", 16'd0, 3'd3, 2'b11, 1'b0);
        quiet(0, "5");
        quiet(0, 8'h08);
        tok(0, "+", 16'd0, 3'd1, 2'b11, 1'b0);

        // Wider instance: full-range operand and overflow edges
        quiet_str(1, "65535");
        tok(1, "*", 16'd65535, 3'd3, 2'b00, 1'b0);
        quiet_str(1, "6553");
        tok(1, "6", 16'd0, 3'd0, 2'b01, 1'b0);
        tok(1, "c", 16'd0, 3'd7, 2'b00, 1'b0);
        quiet_str(1, "00000");
        tok(1, "1", 16'd0, 3'd0, 2'b01, 1'b0);
        tok(1, "c", 16'd0, 3'd7, 2'b00, 1'b0);

        // Reset mid-operand together with a valid '+': no token, outputs cleared
        quiet_str(0, "55");
        rst        = 1'b1;
        in_valid_a = 1'b1;
        in_char_a  = "+";
        @(posedge clk);
        #1;
        rst        = 1'b0;
        in_valid_a = 1'b0;
        chk("rstmid_valid",  32'(out_valid_a),  32'd0);
        chk("rstmid_num",    32'(out_num_a),    32'd0);
        chk("rstmid_mode",   32'(out_mode_a),   32'd0);
        chk("rstmid_status", 32'(out_status_a), 32'd0);
        chk("rstmid_print",  32'(print_en_a),   32'd0);
        quiet(0, "8");
        tok(0, "/", 16'd8, 3'd4, 2'b00, 1'b0);

        chk("sb_empty", 32'(sb_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
